transmit_os_ext: RTL and testbench

TRANSMIT_OS_EXT -- requirements
Module: transmit_os_ext

---
 rtl/transmit_os_ext.sv | 169 ++++++++++++++++
 tb/tb_transmit_os_ext.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_os_ext.sv
// GMII-to-ordered-set transmit control: frame sequencing, carrier extension,
// collision flag and saturating frame/error counters.
module transmit_os_ext #(
    parameter int OS_W   = 9,
    parameter int CNT_W  = 16,
    parameter int EXT_EN = 1,
    parameter int CFG_EN = 1
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic [7:0]       TXD,
    input  logic             TX_EN,
    input  logic             TX_ER,
    input  logic             receiving,
    input  logic             TX_OSET_indicate,
    input  logic             tx_even,
    input  logic [2:0]       xmit,
    input  logic             cnt_clr,
    output logic [OS_W-1:0]  TX_O_SET,
    output logic             transmitting,
    output logic             COL,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [3:0] {
        TX_TEST_XMIT        = 4'd0,
        CONFIGURATION       = 4'd1,
        IDLE                = 4'd2,
        XMIT_DATA           = 4'd3,
        START_OF_PACKET     = 4'd4,
        START_ERROR         = 4'd5,
        TX_PACKET           = 4'd6,
        END_OF_PACKET_NOEXT = 4'd7,
        END_OF_PACKET_EXT   = 4'd8,
        CARRIER_EXTEND      = 4'd9,
        EXTEND_BY_1         = 4'd10,
        EPD2_NOEXT          = 4'd11,
        EPD3                = 4'd12
    } state_t;

    localparam logic [OS_W-1:0] OS_T = OS_W'(1);
    localparam logic [OS_W-1:0] OS_R = OS_W'(2);
    localparam logic [OS_W-1:0] OS_I = OS_W'(3);
    localparam logic [OS_W-1:0] OS_D = OS_W'(4);
    localparam logic [OS_W-1:0] OS_S = OS_W'(5);
    localparam logic [OS_W-1:0] OS_V = OS_W'(6);
    localparam logic [OS_W-1:0] OS_C = OS_W'(8);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] xmit_old;
    logic       mark;
    logic       is_data;
    logic       is_cfg;
    logic       er_eff;
    logic       restart;
    logic       void_v;
    logic       in_start;
    logic       entry;
    logic       leave_pkt;

    // Without carrier extension, an error request outside a frame is just noise.
    always_comb begin
        is_data   = (xmit == 3'd2);
        is_cfg    = (xmit == 3'd4) && (CFG_EN != 0);
        er_eff    = TX_ER && (TX_EN || (EXT_EN != 0));
        restart   = (xmit != xmit_old) && TX_OSET_indicate && !tx_even;
        void_v    = er_eff && (TX_EN || (TXD != 8'h0F));
        in_start  = (state == START_OF_PACKET) || (state == START_ERROR);
        entry     = ((state_nxt == START_OF_PACKET) || (state_nxt == START_ERROR)) && !in_start;
        leave_pkt = (state == TX_PACKET) && (state_nxt != TX_PACKET);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_TEST_XMIT: begin
                if (is_cfg)
                    state_nxt = CONFIGURATION;
                else if (is_data && !TX_EN && !er_eff)
                    state_nxt = XMIT_DATA;
                else
                    state_nxt = IDLE;
            end
            CONFIGURATION: state_nxt = CONFIGURATION;
            IDLE: if (TX_OSET_indicate && is_data && !TX_EN && !er_eff) state_nxt = XMIT_DATA;
            XMIT_DATA: if (TX_OSET_indicate && TX_EN)
                state_nxt = er_eff ? START_ERROR : START_OF_PACKET;
            START_OF_PACKET, START_ERROR: if (TX_OSET_indicate) state_nxt = TX_PACKET;
            TX_PACKET: if (TX_OSET_indicate && !TX_EN)
                state_nxt = er_eff ? END_OF_PACKET_EXT : END_OF_PACKET_NOEXT;
            END_OF_PACKET_NOEXT, EXTEND_BY_1: if (TX_OSET_indicate) state_nxt = EPD2_NOEXT;
            END_OF_PACKET_EXT: if (TX_OSET_indicate)
                state_nxt = er_eff ? CARRIER_EXTEND : EXTEND_BY_1;
            CARRIER_EXTEND: begin
                if (TX_OSET_indicate && TX_EN)
                    state_nxt = er_eff ? START_ERROR : START_OF_PACKET;
                else if (TX_OSET_indicate && !er_eff)
                    state_nxt = EXTEND_BY_1;
            end
            EPD2_NOEXT: if (TX_OSET_indicate) state_nxt = tx_even ? EPD3 : XMIT_DATA;
            EPD3: if (TX_OSET_indicate) state_nxt = XMIT_DATA;
            default: state_nxt = TX_TEST_XMIT;
        endcase
        if (restart)
            state_nxt = TX_TEST_XMIT;
    end

    always_comb begin
        TX_O_SET = OS_I;
        case (state)
            CONFIGURATION:                    TX_O_SET = OS_C;
            START_OF_PACKET, START_ERROR:     TX_O_SET = OS_S;
            TX_PACKET:                        TX_O_SET = void_v ? OS_V : OS_D;
            END_OF_PACKET_NOEXT:              TX_O_SET = OS_T;
            END_OF_PACKET_EXT, CARRIER_EXTEND: TX_O_SET = void_v ? OS_V : OS_R;
            EXTEND_BY_1, EPD2_NOEXT, EPD3:    TX_O_SET = OS_R;
            default:                          TX_O_SET = OS_I;
        endcase
        if (mr_main_reset)
            TX_O_SET = OS_I;
    end

    assign COL = transmitting && receiving;

    // The error mark lives for one frame: set on /V/-causing input, consumed when TX_PACKET is left.
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state        <= TX_TEST_XMIT;
            transmitting <= 1'b0;
            mark         <= 1'b0;
            pkt_cnt      <= '0;
            err_cnt      <= '0;
            xmit_old     <= xmit;
        end else begin
            state    <= state_nxt;
            xmit_old <= xmit;

            if (restart)
                transmitting <= 1'b0;
            else if (entry)
                transmitting <= 1'b1;
            else if (state == EPD2_NOEXT)
                transmitting <= 1'b0;
            else if (((state == END_OF_PACKET_NOEXT) || (state == END_OF_PACKET_EXT) ||
                      (state == EXTEND_BY_1)) && !tx_even)
                transmitting <= 1'b0;

            if (leave_pkt || restart)
                mark <= 1'b0;
            else if ((state == TX_PACKET) && TX_OSET_indicate && TX_EN && TX_ER)
                mark <= 1'b1;
            else if (entry && (state_nxt == START_ERROR))
                mark <= 1'b1;

            if (cnt_clr) begin
                pkt_cnt <= '0;
                err_cnt <= '0;
            end else begin
                if (entry && (pkt_cnt != {CNT_W{1'b1}}))
                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                if (leave_pkt && mark && (err_cnt != {CNT_W{1'b1}}))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_transmit_os_ext.sv
// Bench for transmit_os_ext: directed vector table, random traffic against a
// behavioural model, and counter saturation on a narrow-counter variant.
module tb_transmit_os_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, er, ind, even, recv, clr;
    logic [2:0] xmit;
    logic [7:0] txd;

    logic [8:0]  oset1, oset2;
    logic        tr1, tr2, col1, col2;
    logic [15:0] pkt1, err1;
    logic [3:0]  pkt2, err2;

    transmit_os_ext dut1 (
        .GTX_CLK(clk), .mr_main_reset(rst), .TXD(txd), .TX_EN(en), .TX_ER(er),
        .receiving(recv), .TX_OSET_indicate(ind), .tx_even(even), .xmit(xmit),
        .cnt_clr(clr), .TX_O_SET(oset1), .transmitting(tr1), .COL(col1),
        .pkt_cnt(pkt1), .err_cnt(err1)
    );

    transmit_os_ext #(.CNT_W(4), .EXT_EN(0), .CFG_EN(0)) dut2 (
        .GTX_CLK(clk), .mr_main_reset(rst), .TXD(txd), .TX_EN(en), .TX_ER(er),
        .receiving(recv), .TX_OSET_indicate(ind), .tx_even(even), .xmit(xmit),
        .cnt_clr(clr), .TX_O_SET(oset2), .transmitting(tr2), .COL(col2),
        .pkt_cnt(pkt2), .err_cnt(err2)
    );

    typedef struct packed {
        logic       rst;
        logic [2:0] xmit;
        logic       en;
        logic       er;
        logic [7:0] txd;
        logic       ind;
        logic       even;
        logic       recv;
        logic       clr;
    } stim_t;

    typedef struct {
        stim_t s;
        int    os;
        bit    tr;
        int    pkt;
        int    err;
    } vec_t;

    typedef struct packed {
        int         st;
        bit         trans;
        bit         mark;
        int         pkt;
        int         err;
        logic [2:0] xold;
    } mdl_t;

    localparam int S_TEST = 0, S_CFG = 1, S_IDLE = 2, S_WAIT = 3, S_SOP = 4, S_SERR = 5,
                   S_PKT = 6, S_EOPN = 7, S_EOPX = 8, S_CEXT = 9, S_EXT1 = 10,
                   S_EPD2 = 11, S_EPD3 = 12;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    mdl_t m1, m2;
    vec_t tbl[$];

    function automatic int os_of(int st, stim_t s, bit ext);
        bit e, v;
        e = s.er && (s.en || ext);
        v = e && (s.en || (s.txd != 8'h0F));
        if (s.rst) return 3;
        case (st)
            S_CFG:                  return 8;
            S_SOP, S_SERR:          return 5;
            S_PKT:                  return v ? 6 : 4;
            S_EOPN:                 return 1;
            S_EOPX, S_CEXT:         return v ? 6 : 2;
            S_EXT1, S_EPD2, S_EPD3: return 2;
            default:                return 3;
        endcase
    endfunction

    function automatic mdl_t m_step(mdl_t m, stim_t s, bit ext, bit cfg, int cmax);
        mdl_t n;
        int   nx;
        bit   e, data, cf, restart, entry, leave;
        n = m;
        n.xold = s.xmit;
        if (s.rst) begin
            n.st = S_TEST; n.trans = 0; n.mark = 0; n.pkt = 0; n.err = 0;
            return n;
        end
        e       = s.er && (s.en || ext);
        data    = (s.xmit == 3'd2);
        cf      = cfg && (s.xmit == 3'd4);
        restart = (s.xmit != m.xold) && s.ind && !s.even;
        nx = m.st;
        case (m.st)
            S_TEST: nx = cf ? S_CFG : (data && !s.en && !e) ? S_WAIT : S_IDLE;
            S_IDLE: if (s.ind && data && !s.en && !e) nx = S_WAIT;
            S_WAIT: if (s.ind && s.en) nx = e ? S_SERR : S_SOP;
            S_SOP, S_SERR: if (s.ind) nx = S_PKT;
            S_PKT: if (s.ind && !s.en) nx = e ? S_EOPX : S_EOPN;
            S_EOPN, S_EXT1: if (s.ind) nx = S_EPD2;
            S_EOPX: if (s.ind) nx = e ? S_CEXT : S_EXT1;
            S_CEXT: if (s.ind) begin
                if (s.en) nx = e ? S_SERR : S_SOP;
                else if (!e) nx = S_EXT1;
            end
            S_EPD2: if (s.ind) nx = s.even ? S_EPD3 : S_WAIT;
            S_EPD3: if (s.ind) nx = S_WAIT;
            S_CFG: nx = S_CFG;
            default: nx = S_TEST;
        endcase
        if (restart) nx = S_TEST;
        entry = (nx == S_SOP || nx == S_SERR) && !(m.st == S_SOP || m.st == S_SERR);
        leave = (m.st == S_PKT) && (nx != S_PKT);

        if (restart) n.trans = 0;
        else if (entry) n.trans = 1;
        else if (m.st == S_EPD2) n.trans = 0;
        else if ((m.st == S_EOPN || m.st == S_EOPX || m.st == S_EXT1) && !s.even) n.trans = 0;

        if (leave || restart) n.mark = 0;
        else if (m.st == S_PKT && s.ind && s.en && s.er) n.mark = 1;
        else if (entry && nx == S_SERR) n.mark = 1;

        if (s.clr) begin
            n.pkt = 0; n.err = 0;
        end else begin
            if (entry && m.pkt < cmax) n.pkt = m.pkt + 1;
            if (leave && m.mark && m.err < cmax) n.err = m.err + 1;
        end
        n.st = nx;
        return n;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int e_os, input bit e_tr, input bit e_col,
                               input int e_pkt, input int e_err, input int a_os, input logic a_tr,
                               input logic a_col, input int a_pkt, input int a_err);
        checkValue({tag, ".TX_O_SET"}, a_os, e_os);
        checkValue({tag, ".transmitting"}, int'(a_tr === 1'b1), int'(e_tr));
        checkValue({tag, ".COL"}, int'(a_col === 1'b1), int'(e_col));
        checkValue({tag, ".pkt_cnt"}, a_pkt, e_pkt);
        checkValue({tag, ".err_cnt"}, a_err, e_err);
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later, well before the rising edge.
    task automatic applyStimulus(input stim_t s, input bit chk, input bit use_tbl, input int e_os,
                                 input bit e_tr, input int e_pkt, input int e_err);
        @(negedge clk);
        rst = s.rst; xmit = s.xmit; en = s.en; er = s.er; txd = s.txd;
        ind = s.ind; even = s.even; recv = s.recv; clr = s.clr;
        #1;
        if (chk) begin
            if (!use_tbl) begin
                e_os = os_of(m1.st, s, 1'b1); e_tr = m1.trans; e_pkt = m1.pkt; e_err = m1.err;
            end
            checkOutput("d1", e_os, e_tr, e_tr && s.recv, e_pkt, e_err,
                        int'(oset1), tr1, col1, int'(pkt1), int'(err1));
            checkOutput("d2", os_of(m2.st, s, 1'b0), m2.trans, m2.trans && s.recv, m2.pkt, m2.err,
                        int'(oset2), tr2, col2, int'(pkt2), int'(err2));
        end
        @(posedge clk);
        m1 = m_step(m1, s, 1'b1, 1'b1, 65535);
        m2 = m_step(m2, s, 1'b0, 1'b0, 15);
        cyc++;
    endtask

    function automatic stim_t mk(bit r, int x, bit e_n, bit e_r, int d, bit ev, bit rc, bit cl);
        stim_t s;
        s.rst = r; s.xmit = 3'(x); s.en = e_n; s.er = e_r; s.txd = 8'(d);
        s.ind = 1'b1; s.even = ev; s.recv = rc; s.clr = cl;
        return s;
    endfunction

    task automatic add(input bit r, input int x, input bit e_n, input bit e_r, input int d,
                       input bit ev, input bit rc, input bit cl,
                       input int os, input bit tr, input int pk, input int ec);
        vec_t v;
        v.s = mk(r, x, e_n, e_r, d, ev, rc, cl);
        v.os = os; v.tr = tr; v.pkt = pk; v.err = ec;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t s;
        bit    cur_en;
        rst = 1'b1; xmit = 3'd2; en = 0; er = 0; txd = 8'h55; ind = 1; even = 0; recv = 0; clr = 0;
        m1 = '0; m2 = '0;
        for (int i = 0; i < 2; i++) applyStimulus(mk(1, 2, 0, 0, 'h55, 0, 0, 0), 0, 0, 0, 0, 0, 0);

        //  rst x en er txd  ev rc cl   os tr pkt err
        add(1, 2, 0, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  5, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  4, 1, 1, 0);
        add(0, 2, 1, 1, 'h55, 0, 0, 0,  6, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  4, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  4, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  4, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  1, 1, 1, 1);
        add(0, 2, 0, 0, 'h55, 1, 0, 0,  2, 0, 1, 1);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  2, 0, 1, 1);
        add(0, 2, 0, 0, 'h55, 0, 0, 1,  3, 0, 1, 1);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 1, 0, 'h55, 0, 1, 0,  5, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 1, 0,  4, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 1, 0,  4, 1, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 1, 0,  4, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 1, 0,  4, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 1, 0,  1, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 1, 0,  2, 0, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  3, 0, 1, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  5, 1, 2, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  4, 1, 2, 0);
        add(0, 2, 0, 1, 'h0F, 0, 0, 0,  4, 1, 2, 0);
        add(0, 2, 0, 1, 'h0F, 0, 0, 0,  2, 1, 2, 0);
        add(0, 2, 0, 1, 'h0F, 0, 0, 0,  2, 0, 2, 0);
        add(0, 2, 0, 1, 'h00, 0, 0, 0,  6, 0, 2, 0);
        add(0, 2, 0, 0, 'h0F, 0, 0, 0,  2, 0, 2, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  2, 0, 2, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  2, 0, 2, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  3, 0, 2, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  5, 1, 3, 0);
        add(0, 4, 1, 0, 'h55, 0, 0, 0,  4, 1, 3, 0);
        add(0, 4, 1, 0, 'h55, 0, 0, 0,  3, 0, 3, 0);
        add(0, 4, 0, 0, 'h55, 0, 0, 0,  8, 0, 3, 0);
        add(0, 4, 0, 0, 'h55, 1, 0, 0,  8, 0, 3, 0);
        add(1, 2, 0, 0, 'h55, 0, 0, 1,  3, 0, 3, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        add(0, 2, 1, 0, 'h55, 0, 0, 0,  5, 1, 1, 0);
        add(0, 2, 1, 1, 'h55, 0, 0, 0,  6, 1, 1, 0);
        add(1, 2, 1, 0, 'h55, 0, 0, 0,  3, 1, 1, 0);
        add(0, 2, 0, 0, 'h55, 0, 0, 0,  3, 0, 0, 0);
        foreach (tbl[i]) applyStimulus(tbl[i].s, 1, 1, tbl[i].os, tbl[i].tr, tbl[i].pkt, tbl[i].err);

        cur_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 7) == 0) cur_en = ~cur_en;
            r = $urandom_range(0, 99);
            s.xmit = (r < 90) ? 3'd2 : (r < 94) ? 3'd4 : (r < 97) ? 3'd1 : 3'($urandom_range(0, 7));
            s.en   = cur_en;
            s.er   = ($urandom_range(0, cur_en ? 9 : 2) == 0);
            s.txd  = ($urandom_range(0, 3) != 0) ? 8'h0F : 8'($urandom_range(0, 255));
            s.ind  = ($urandom_range(0, 3) != 0);
            s.even = 1'($urandom_range(0, 1));
            s.recv = 1'($urandom_range(0, 1));
            s.clr  = ($urandom_range(0, 99) == 0);
            s.rst  = ($urandom_range(0, 399) == 0);
            applyStimulus(s, 1, 0, 0, 0, 0, 0);
        end

        applyStimulus(mk(1, 2, 0, 0, 'h55, 0, 0, 0), 1, 0, 0, 0, 0, 0);
        applyStimulus(mk(0, 2, 0, 0, 'h55, 0, 0, 0), 1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 21; f++) begin
            applyStimulus(mk(0, 2, 1, 0, 'h55, 0, 1, f == 20), 1, 0, 0, 0, 0, 0);
            if (f == 20) begin
                #1;
                checkValue("clr_beats_inc.pkt1", int'(pkt1), 0);
                checkValue("clr_beats_inc.pkt2", int'(pkt2), 0);
            end
            applyStimulus(mk(0, 2, 1, 0, 'h55, 0, 1, 0), 1, 0, 0, 0, 0, 0);
            applyStimulus(mk(0, 2, 1, 1, 'h55, 0, 1, 0), 1, 0, 0, 0, 0, 0);
            applyStimulus(mk(0, 2, 0, 0, 'h55, 0, 1, 0), 1, 0, 0, 0, 0, 0);
            applyStimulus(mk(0, 2, 0, 0, 'h55, 0, 1, 0), 1, 0, 0, 0, 0, 0);
            applyStimulus(mk(0, 2, 0, 0, 'h55, 0, 1, 0), 1, 0, 0, 0, 0, 0);
            if (f == 19) begin
                #1;
                checkValue("sat.pkt1", int'(pkt1), 20);
                checkValue("sat.err1", int'(err1), 20);
                checkValue("sat.pkt2", int'(pkt2), 15);
                checkValue("sat.err2", int'(err2), 15);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
